byte_data_memory: RTL



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/load_store_align.sv | 72 +++++++
 rtl/byte_data_memory.sv | 75 +++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, clear-FSM states and funct3 helper for byte_data_memory
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // True for the five funct3 codes that describe a real load/store size
  function automatic logic is_legal_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - lane steering, byte enables, load extension and misalignment check
module load_store_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic        legal;
  logic [1:0]  size;
  logic [31:0] shifted;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign legal   = is_legal_f3(funct3);
  assign size    = funct3[1:0];
  assign shifted = rword >> {addr_lo, 3'b000};
  assign rbyte   = shifted[7:0];
  assign rhalf   = addr_lo[1] ? rword[31:16] : rword[15:0];

  // Halves need an even address, words a 4-byte aligned one; illegal codes never flag
  always_comb begin
    misaligned = 1'b0;
    if (legal) begin
      case (size)
        2'b01:   misaligned = addr_lo[0];
        2'b10:   misaligned = (addr_lo != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end
  end

  // Replicate the LSB-aligned source into every lane and enable only the addressed ones
  always_comb begin
    byte_en = 4'b0000;
    wword   = wdata;
    if (legal) begin
      case (size)
        2'b00: begin
          byte_en = 4'b0001 << addr_lo;
          wword   = {4{wdata[7:0]}};
        end
        2'b01: begin
          byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
          wword   = {2{wdata[15:0]}};
        end
        2'b10:   byte_en = 4'b1111;
        default: byte_en = 4'b0000;
      endcase
    end
  end

  // Pick the addressed lane and extend according to the signedness bit
  always_comb begin
    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{rbyte[7]}}, rbyte};
      F3_BU:   rdata = {24'b0, rbyte};
      F3_H:    rdata = {{16{rhalf[15]}}, rhalf};
      F3_HU:   rdata = {16'b0, rhalf};
      F3_W:    rdata = rword;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/byte_data_memory.sv
// rtl/byte_data_memory.sv - word RAM with RISC-V sub-word loads/stores and post-reset clear
module byte_data_memory
  import dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     address,
  input  logic [XLEN-1:0] writeData,
  input  logic            writeEnable,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] readData,
  output logic            misaligned,
  output logic            busy
);

  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH_WORDS - 1);

  logic [31:0]      mem [DEPTH_WORDS];
  clr_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rword;
  logic [31:0]      wword;
  logic [31:0]      load_val;
  logic [3:0]       byte_en;
  logic             legal;
  logic             store_ok;
  logic             unused_addr;

  assign idx         = address[IDX_W+1:2];
  assign unused_addr = ^address[31:IDX_W+2];
  assign rword       = mem[idx];
  assign legal       = is_legal_f3(funct3);
  assign busy        = (state == CLEAR);
  assign store_ok    = rst && writeEnable && !busy && legal && !misaligned;
  assign readData    = (busy || misaligned || !legal) ? '0 : load_val;

  load_store_align u_align (
    .addr_lo    (address[1:0]),
    .funct3     (funct3),
    .wdata      (writeData),
    .rword      (rword),
    .byte_en    (byte_en),
    .wword      (wword),
    .rdata      (load_val),
    .misaligned (misaligned)
  );

  // Clear sequencer: walk ptr over every word once after reset, then sit in READY
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == LAST_PTR) state <= READY;
    end
  end

  // Array writes: clearing owns the port while busy, otherwise gated byte-lane stores
  always_ff @(posedge clk) begin
    if (rst && state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule
